// File: rtl/quad_sched.sv
// rtl/quad_sched.sv - round-robin scheduler feeding a shared sum-of-squares datapath, tagged result FIFO
// Optional issue/stall counters are compiled in when QUAD_SCHED_STATS_EN is defined.
module quad_sched #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*14-1:0]      req_a,
  input  logic [NREQ*14-1:0]      req_b,
  output logic [13:0]             dp_a,
  output logic [13:0]             dp_b,
  input  logic [28:0]             dp_c,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [28:0]             res_data,
`ifdef QUAD_SCHED_STATS_EN
  output logic [15:0]             stat_issued,
  output logic [15:0]             stat_stall,
`endif
  output logic [$clog2(NREQ)-1:0] res_tag
);
  localparam int TW = $clog2(NREQ);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [TW-1:0]  last_grant;
  logic [TW-1:0]  grant_idx;
  logic           grant_found;
  logic           issue;
  logic           pop;
  logic           wr_en;
  logic [OW-1:0]  occ;
  logic [OW-1:0]  stored;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LAT-1:0] pipe_valid;
  logic [TW-1:0]  pipe_tag [LAT];
  logic [28:0]    mem_data [DEPTH];
  logic [TW-1:0]  mem_tag  [DEPTH];

  // Search starts one past the last grant; k = NREQ wraps back to last_grant itself.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_found && req_valid[last_grant + TW'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = last_grant + TW'(k);
      end
    end
  end

  // Credit uses occ as registered at the start of the cycle, so a same-cycle pop frees nothing yet.
  assign issue     = rstn && grant_found && (occ < OW'(DEPTH));
  assign req_ready = issue ? (NREQ'(1) << grant_idx) : '0;
  assign dp_a      = issue ? req_a[32'(grant_idx) * 14 +: 14] : '0;
  assign dp_b      = issue ? req_b[32'(grant_idx) * 14 +: 14] : '0;

  assign wr_en     = pipe_valid[LAT-1];
  assign res_valid = (stored != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = mem_data[rd_ptr];
  assign res_tag   = mem_tag[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= TW'(NREQ - 1);
      occ        <= '0;
      stored     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pipe_valid <= '0;
      for (int i = 0; i < LAT; i++) pipe_tag[i] <= '0;
    end else begin
      if (issue) last_grant <= grant_idx;
      occ    <= occ + OW'(issue) - OW'(pop);
      stored <= stored + OW'(wr_en) - OW'(pop);
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      pipe_valid[0] <= issue;
      pipe_tag[0]   <= grant_idx;
      for (int i = 1; i < LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
    end
  end

  // Storage needs no reset: entries are only visible through the reset-cleared count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= dp_c;
      mem_tag[wr_ptr]  <= pipe_tag[LAT-1];
    end
  end

`ifdef QUAD_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue && stat_issued != 16'hFFFF)
        stat_issued <= stat_issued + 16'd1;
      if ((|req_valid) && !issue && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_quad_sched.sv
// tb/tb_quad_sched.sv - randomized scoreboard bench for quad_sched with a behavioural issue/result model
module tb_quad_sched;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic [28:0] d;
    logic [1:0]  t;
  } ent_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*14-1:0] req_a = '0;
  logic [NREQ*14-1:0] req_b = '0;
  logic [13:0]       dp_a;
  logic [13:0]       dp_b;
  logic [28:0]       dp_c;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [28:0]       res_data;
  logic [1:0]        res_tag;
`ifdef QUAD_SCHED_STATS_EN
  logic [15:0]       stat_issued;
  logic [15:0]       stat_stall;
`endif

  int passed = 0;
  int total  = 0;

  ent_t        sb[$];
  int          m_avail[$];
  int          m_lg = NREQ - 1;
  int          cyc = 0;
  int          m_issued = 0;
  int          m_stall = 0;
  logic [13:0] opa [NREQ];
  logic [13:0] opb [NREQ];

  logic            last_hs;
  logic            last_rv;
  logic [28:0]     last_rd;
  logic [1:0]      last_rt;
  logic [NREQ-1:0] last_rdy;
  ent_t            mon_e;

  quad_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_c      (dp_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
`ifdef QUAD_SCHED_STATS_EN
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall),
`endif
    .res_tag   (res_tag)
  );

  always #5 clk = ~clk;

  // Shared datapath: LAT register stages, synchronous reset.
  logic [28:0] dp_pipe [LAT];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) dp_pipe[i] <= '0;
    end else begin
      dp_pipe[0] <= 29'(dp_a) * 29'(dp_a) + 29'(dp_b) * 29'(dp_b);
      for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
  end
  assign dp_c = dp_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [28:0] sq(input int a, input int b);
    longint s;
    s = longint'(a) * a + longint'(b) * b;
    return 29'(s);
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = 14'($urandom);
      opb[i] = 14'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = '1;
    rstn = 1'b0;
    #1;
    chk("reset_res_valid", res_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    req_valid = '0;
    rstn = 1'b1;
    m_avail.delete();
    sb.delete();
    m_lg = NREQ - 1;
    cyc = 0;
    m_issued = 0;
    m_stall = 0;
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model past the next edge.
  task automatic step(input logic [NREQ-1:0] v, input logic rr);
    int              g;
    bit              found;
    bit              iss;
    bit              erv;
    logic [NREQ-1:0] exp_rdy;
    ent_t            ne;
    @(negedge clk);
    req_valid = v;
    res_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[14*i +: 14] = opa[i];
      req_b[14*i +: 14] = opb[i];
    end
    #2;
    found = 0;
    g = 0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && v[(m_lg + k) % NREQ]) begin
        found = 1;
        g = (m_lg + k) % NREQ;
      end
    end
    iss = found && (m_avail.size() < DEPTH);
    exp_rdy = '0;
    if (iss) exp_rdy[g] = 1'b1;
    erv = (m_avail.size() > 0) && (m_avail[0] <= cyc);
    chk("req_ready", req_ready, exp_rdy);
    chk("dp_a", dp_a, iss ? opa[g] : 14'd0);
    chk("dp_b", dp_b, iss ? opb[g] : 14'd0);
    chk("res_valid", res_valid, erv);
`ifdef QUAD_SCHED_STATS_EN
    chk("stat_issued", stat_issued, m_issued);
    chk("stat_stall", stat_stall, m_stall);
    if (iss) m_issued++;
    else if (|v) m_stall++;
`endif
    last_hs  = |(req_ready & v);
    last_rv  = res_valid;
    last_rd  = res_data;
    last_rt  = res_tag;
    last_rdy = req_ready;
    if (iss) begin
      m_avail.push_back(cyc + 1 + LAT);
      ne.d = sq(opa[g], opb[g]);
      ne.t = 2'(g);
      sb.push_back(ne);
      m_lg = g;
    end
    if (erv && rr) void'(m_avail.pop_front());
    cyc++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rstn && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL sb_underflow: got result %0d tag %0d, expected none", res_data, res_tag);
        end else begin
          mon_e = sb.pop_front();
          chk("res_data", res_data, mon_e.d);
          chk("res_tag", res_tag, mon_e.t);
        end
      end
    end
  end

  initial begin
    int n;
    int hs;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    do_reset();

    // Single request: 3*3 + 4*4
    opa[0] = 14'd3;
    opb[0] = 14'd4;
    step(4'b0001, 1'b1);
    n = 1;
    for (int i = 0; i < 10 && !last_rv; i++) begin
      step(4'b0000, 1'b1);
      if (!last_rv) n++;
    end
    chk("latency_edges", n, LAT + 1);
    chk("single_data", last_rd, 25);
    chk("single_tag", last_rt, 0);
    repeat (LAT + 3) step(4'b0000, 1'b1);

    // All requesters valid after reset: strict rotation, one issue per cycle
    do_reset();
    hs = 0;
    for (int i = 0; i < 12; i++) begin
      randomize_ops();
      step(4'b1111, 1'b1);
      chk("rr_order", onehot_idx(last_rdy), i % NREQ);
      if (last_hs) hs++;
    end
    chk("rr_issues", hs, 12);
    repeat (LAT + 4) step(4'b0000, 1'b1);

    // Credit exhaustion with no consumer
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      randomize_ops();
      step(4'b0010, 1'b0);
      if (last_hs) hs++;
    end
    chk("credit_issues", hs, DEPTH);
    step(4'b0010, 1'b1);
    chk("pop_cycle_no_issue", last_hs, 0);
    step(4'b0010, 1'b1);
    chk("issue_after_pop", last_hs, 1);
    repeat (DEPTH + LAT + 4) step(4'b0000, 1'b1);

    // Maximum operands
    opa[2] = 14'd16383;
    opb[2] = 14'd16383;
    step(4'b0100, 1'b1);
    for (int i = 0; i < 10 && !last_rv; i++) step(4'b0000, 1'b1);
    chk("max_operands", last_rd, 29'd536805378);
    repeat (LAT + 3) step(4'b0000, 1'b1);

    // Reset with two results in flight and two stored
    randomize_ops();
    repeat (4) step(4'b0001, 1'b0);
    do_reset();
    randomize_ops();
    step(4'b1111, 1'b1);
    chk("first_grant_after_reset", last_rdy, 4'b0001);
    repeat (LAT + 4) step(4'b0000, 1'b1);

    // Random traffic with intermittent back-pressure
    repeat (300) begin
      randomize_ops();
      step(NREQ'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (DEPTH + LAT + 6) step(4'b0000, 1'b1);

    // Back-to-back run across pointer wrap
    hs = 0;
    repeat (20) begin
      randomize_ops();
      step(4'b1111, 1'b1);
      if (last_hs) hs++;
    end
    chk("back_to_back_issues", hs, 20);
    repeat (DEPTH + LAT + 6) step(4'b0000, 1'b1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/quad_sched.md
QUAD_SCHED -- requirements
Module: quad_sched

Interface
REQ-001 Parameter NREQ, 4, number of requesters, power of two, at least 2.
REQ-002 Parameter LAT, 2, clock edges from operand sample to dp_c valid on the shared sum-of-squares datapath.
REQ-003 Parameter DEPTH, 4, result FIFO entries, power of two.
REQ-004 Port clk  in  1  single clock, rising edge.
REQ-005 Port rstn  in  1  reset; asynchronous assert, active-low.
REQ-006 Port req_valid  in  NREQ  per-requester operand valid.
REQ-007 Port req_ready  out  NREQ  per-requester accept; at most one bit high.
REQ-008 Port req_a  in  NREQ*14  packed operand a; requester i at bits [14i+13:14i].
REQ-009 Port req_b  in  NREQ*14  packed operand b, same packing.
REQ-010 Port dp_a  out  14  operand a to the datapath.
REQ-011 Port dp_b  out  14  operand b to the datapath.
REQ-012 Port dp_c  in  29  datapath result a*a+b*b, unsigned.
REQ-013 Port res_valid  out  1  result available.
REQ-014 Port res_ready  in  1  result consumer accept.
REQ-015 Port res_data  out  29  result value.
REQ-016 Port res_tag  out  log2(NREQ)  index of the originating requester.

Function
REQ-017 Arbitration: round-robin; the search starts at last_grant+1 modulo NREQ; the first requester with req_valid high is granted.
REQ-018 Issue occurs when a grant exists and occ < DEPTH; req_ready[g] = grant[g] AND issue; the handshake completes at the edge where req_valid and req_ready are both high.
REQ-019 last_grant updates only on issue; it is unchanged when no request is present or when credit is blocked.
REQ-020 dp_a and dp_b are combinational; they equal the granted operands during an issue cycle and 0 otherwise.
REQ-021 Tag pipeline: a valid/tag shift register of depth LAT loads {issue, grant index} at the issue edge T; dp_c is written into the FIFO at edge T+LAT with that tag.
REQ-022 Idle datapath cycles carry no valid bit and are never written into the FIFO.
REQ-023 occ (width log2(DEPTH)+1) counts in-flight plus stored results: +1 on issue, -1 on pop, net 0 when both occur in the same cycle.
REQ-024 The credit check uses occ registered at the start of the cycle; a same-cycle pop does not free credit until the next cycle.
REQ-025 FIFO: circular read and write pointers wrap modulo DEPTH; res_valid = stored count != 0; res_data and res_tag come from the head entry.
REQ-026 Pop occurs when res_valid and res_ready are both high; res_data and res_tag stay stable while res_valid is high and res_ready is low.
REQ-027 No bypass: a write into an empty FIFO makes res_valid high one cycle after the write edge.
REQ-028 Overflow cannot occur because of the credit check; a simultaneous write and pop while full keeps the count unchanged.
REQ-029 Throughput: one issue per cycle while credit is available; with res_ready held high and NREQ requests continuously valid, issues are sustained back-to-back.
REQ-030 Minimum handshake-to-res_valid latency is LAT+1 rising edges.

Reset
REQ-031 While rstn is low: req_ready=0, res_valid=0, occ=0, FIFO pointers=0, tag pipeline valids=0, last_grant=NREQ-1 so requester 0 wins first.
REQ-032 Reset mid-operation discards in-flight and stored results; the first issue after release follows REQ-031 state.
REQ-033 The shared datapath uses synchronous reset on the same rstn; its output is ignored because the tag valids are cleared.

Configuration
REQ-034 Macro QUAD_SCHED_STATS_EN defined: adds ports stat_issued (out 16) and stat_stall (out 16).
REQ-035 stat_issued increments on each issue; stat_stall increments each cycle any req_valid is high with no issue; both saturate at 0xFFFF and reset to 0.
REQ-036 Macro QUAD_SCHED_STATS_EN undefined: the stat ports and counters are absent; all other behaviour is identical.

Verification
REQ-037 Single request: req0 a=3, b=4, res_ready=1 -> res_data=25, res_tag=0, res_valid rises LAT+1 edges after the handshake.
REQ-038 All four requesters valid continuously, res_ready=1 -> grant order 0,1,2,3,0,... with one issue per cycle.
REQ-039 res_ready=0 and req1 always valid -> exactly DEPTH=4 issues, then req_ready=0; stat_stall counts every blocked cycle (macro on); a later pop re-enables issue one cycle after the pop.
REQ-040 Maximum operands a=b=16383 -> res_data=536805378, no truncation.
REQ-041 rstn asserted with 2 results in flight and 2 stored -> res_valid=0 immediately; after release no stale result appears and requester 0 is granted first.
REQ-042 Simultaneous pop and FIFO write across pointer wrap over 20 back-to-back operations -> results emerge in issue order with correct tags.
